// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional macro BTB_STATS_EN adds saturating lookup/hit/mispredict counters.
module branch_target_predictor #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 16,
    parameter int TAG_WIDTH = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_valid,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    output logic            upd_mispredict
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [1:0] CTR_SN = 2'b00;
    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;

    logic [IDX_W-1:0]     if_idx, upd_idx;
    logic [TAG_WIDTH-1:0] if_tag, upd_tag;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[IDX_W+TAG_WIDTH+1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+TAG_WIDTH+1:IDX_W+2];

    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
    logic [TAG_WIDTH-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0]      target_q [ENTRIES];
    logic [XLEN-1:0]      target_d [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];
    logic [1:0]           ctr_d    [ENTRIES];
    logic                 upd_hit;

    // Lookup reads only registered state, so a same-cycle update is not visible.
    assign pred_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken     = pred_hit && ctr_q[if_idx][1];
    assign pred_target    = pred_hit ? target_q[if_idx] : '0;
    assign upd_mispredict = upd_valid && (upd_taken != upd_pred_taken);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (upd_valid && !rst) begin
            if (upd_hit) begin
                if (upd_jump) begin
                    ctr_d[upd_idx] = CTR_ST;
                end else if (upd_taken) begin
                    ctr_d[upd_idx] = (ctr_q[upd_idx] == CTR_ST) ? CTR_ST : ctr_q[upd_idx] + 2'b01;
                end else begin
                    ctr_d[upd_idx] = (ctr_q[upd_idx] == CTR_SN) ? CTR_SN : ctr_q[upd_idx] - 2'b01;
                end
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = upd_jump ? CTR_ST : CTR_WT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_SN;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // NOTE: tag/target storage is not reset; an entry is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, lookups_d;
    logic [31:0] hits_q, hits_d;
    logic [31:0] mispredicts_q, mispredicts_d;

    always_comb begin
        lookups_d     = lookups_q;
        hits_d        = hits_q;
        mispredicts_d = mispredicts_q;
        if (if_valid && (lookups_q != '1)) lookups_d = lookups_q + 32'd1;
        if (if_valid && pred_hit && (hits_q != '1)) hits_d = hits_q + 32'd1;
        if (upd_mispredict && (mispredicts_q != '1)) mispredicts_d = mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else begin
            lookups_q     <= lookups_d;
            hits_q        <= hits_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_mispredicts = mispredicts_q;

    logic unused_bits;
    assign unused_bits = ^{if_pc, upd_pc};
`else
    logic unused_bits;
    assign unused_bits = ^{if_pc, upd_pc, if_valid};
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: directed scenarios plus random traffic against an
// array-based reference model of the BTB. Define BTB_STATS_EN to cover statistics.
module tb_branch_target_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic        upd_mispredict;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

    branch_target_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_jump       (upd_jump),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_mispredict (upd_mispredict)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_hits        (stat_hits),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 16 entries, index = pc bits 5:2, tag = pc bits 15:6.
    bit          m_valid  [16];
    int unsigned m_tag    [16];
    int unsigned m_target [16];
    int          m_ctr    [16];
    int unsigned m_lk, m_hit, m_mis;

    function automatic int idx_of(input int unsigned pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return (pc / 64) % 1024;
    endfunction

    function automatic bit model_hit(input int unsigned pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 0;
        end
        m_lk = 0; m_hit = 0; m_mis = 0;
    endtask

    // Check combinational outputs against the model, cross one clock edge, advance the model.
    task automatic tick();
        bit hit_now, mis_now;
        int i;
        #2;
        hit_now = model_hit(if_pc);
        mis_now = upd_valid && (upd_taken != upd_pred_taken);
        i = idx_of(if_pc);
        check("hit", {31'd0, pred_hit}, {31'd0, hit_now});
        check("taken", {31'd0, pred_taken}, {31'd0, hit_now && (m_ctr[i] >= 2)});
        check("target", pred_target, hit_now ? m_target[i] : 32'd0);
        check("mispredict", {31'd0, upd_mispredict}, {31'd0, mis_now});
`ifdef BTB_STATS_EN
        check("stat_lookups", stat_lookups, m_lk);
        check("stat_hits", stat_hits, m_hit);
        check("stat_mispredicts", stat_mispredicts, m_mis);
`endif
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (if_valid && m_lk != 32'hFFFF_FFFF) m_lk++;
            if (if_valid && hit_now && m_hit != 32'hFFFF_FFFF) m_hit++;
            if (mis_now && m_mis != 32'hFFFF_FFFF) m_mis++;
            if (upd_valid) begin
                i = idx_of(upd_pc);
                if (model_hit(upd_pc)) begin
                    if (upd_jump)       m_ctr[i] = 3;
                    else if (upd_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    else                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    if (upd_taken) m_target[i] = upd_target;
                end else if (upd_taken) begin
                    m_valid[i]  = 1;
                    m_tag[i]    = tag_of(upd_pc);
                    m_target[i] = upd_target;
                    m_ctr[i]    = upd_jump ? 3 : 2;
                end
            end
        end
        #1;
    endtask

    task automatic peek(input string tag, input logic [31:0] pc, input logic exp_hit,
                        input logic exp_taken, input logic [31:0] exp_target);
        if_pc     = pc;
        upd_valid = 1'b0;
        #2;
        check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, exp_hit});
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
        check({tag, "_target"}, pred_target, exp_target);
        tick();
    endtask

    task automatic upd(input logic [31:0] pc, input logic jump, input logic taken,
                       input logic [31:0] target);
        if_pc          = pc;
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_jump       = jump;
        upd_taken      = taken;
        upd_target     = target;
        upd_pred_taken = taken;
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        logic walk_out  [6];
        logic walk_pred [6];
        walk_out  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        walk_pred = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; if_pc = '0; if_valid = 1'b0; upd_valid = 1'b0; upd_pc = '0;
        upd_jump = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        peek("reset", 32'h60, 1'b0, 1'b0, 32'h0);

        // Allocation on a taken miss; same-cycle lookup still sees the old entry.
        if_pc = 32'h60; upd_valid = 1'b1; upd_pc = 32'h60; upd_jump = 1'b0;
        upd_taken = 1'b1; upd_target = 32'h40; upd_pred_taken = 1'b0;
        #2;
        check("same_cycle_hit", {31'd0, pred_hit}, 32'd0);
        tick();
        peek("alloc", 32'h60, 1'b1, 1'b1, 32'h40);

        for (int k = 0; k < 6; k++) begin
            upd(32'h60, 1'b0, walk_out[k], 32'h40);
            peek("walk", 32'h60, 1'b1, walk_pred[k], 32'h40);
        end

        upd(32'h460, 1'b0, 1'b1, 32'h100);
        peek("alias_old", 32'h60, 1'b0, 1'b0, 32'h0);
        peek("alias_new", 32'h460, 1'b1, 1'b1, 32'h100);
        upd(32'h860, 1'b0, 1'b0, 32'h999);
        peek("alias_nt", 32'h460, 1'b1, 1'b1, 32'h100);
        upd(32'h460, 1'b0, 1'b0, 32'h0);
        peek("alias_wn", 32'h460, 1'b1, 1'b0, 32'h100);

        upd(32'h80, 1'b1, 1'b1, 32'h200);
        peek("jump", 32'h80, 1'b1, 1'b1, 32'h200);
        upd(32'h80, 1'b0, 1'b0, 32'h0);
        peek("jump_dec1", 32'h80, 1'b1, 1'b1, 32'h200);
        upd(32'h80, 1'b0, 1'b0, 32'h0);
        peek("jump_dec2", 32'h80, 1'b1, 1'b0, 32'h200);

        // An update coinciding with reset is discarded and the table empties.
        rst = 1'b1;
        upd(32'hC0, 1'b1, 1'b1, 32'h300);
        rst = 1'b0;
        peek("rst_disc", 32'hC0, 1'b0, 1'b0, 32'h0);
        peek("rst_clear", 32'h80, 1'b0, 1'b0, 32'h0);

`ifdef BTB_STATS_EN
        upd(32'h60, 1'b0, 1'b1, 32'h40);
        if_valid = 1'b1;
        peek("st1", 32'h60, 1'b1, 1'b1, 32'h40);
        peek("st2", 32'h60, 1'b1, 1'b1, 32'h40);
        peek("st3", 32'h64, 1'b0, 1'b0, 32'h0);
        peek("st4", 32'h68, 1'b0, 1'b0, 32'h0);
        if_pc = 32'h6C; upd_valid = 1'b1; upd_pc = 32'h300; upd_jump = 1'b0;
        upd_taken = 1'b0; upd_pred_taken = 1'b1;
        tick();
        upd_valid = 1'b0; if_valid = 1'b0;
        #2;
        check("stat5_lookups", stat_lookups, 32'd5);
        check("stat5_hits", stat_hits, 32'd2);
        check("stat5_mis", stat_mispredicts, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        check("stat_rst_lookups", stat_lookups, 32'd0);
        check("stat_rst_hits", stat_hits, 32'd0);
        check("stat_rst_mis", stat_mispredicts, 32'd0);
        check("stat_rst_entry", {31'd0, pred_hit}, 32'd0);
`endif

        // Random traffic over a few indices and aliasing tags; bit 20 is outside the tag.
        for (int n = 0; n < 800; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            if_valid       = $urandom_range(0, 1) == 1;
            if_pc          = ($urandom_range(0, 1) << 20) | ($urandom_range(0, 3) << 6)
                           | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            upd_valid      = $urandom_range(0, 9) < 6;
            upd_pc         = ($urandom_range(0, 1) << 20) | ($urandom_range(0, 3) << 6)
                           | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            upd_jump       = $urandom_range(0, 99) < 15;
            upd_taken      = upd_jump || ($urandom_range(0, 1) == 1);
            upd_target     = $urandom;
            upd_pred_taken = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
